// File: rtl/cache_arbiter_pkg.sv
// Shared types and default sizes for the cache-to-memory arbiter.
package arb_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

    localparam int ARB_LINE_WIDTH = 256;
    localparam int ARB_ADDR_WIDTH = 32;

endpackage

// File: rtl/cache_arbiter_chk.sv
// Protocol checker: the D-cache must never request a read and a writeback together.
module cache_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic d_pmem_read,
    input logic d_pmem_write
);

    // Flag an illegal simultaneous D read and write request.
    always @(posedge clk) begin
        if (!rst) begin
            d_rw_exclusive: assert (!(d_pmem_read && d_pmem_write));
        end
    end

endmodule

// File: rtl/cache_arbiter_select.sv
// Combinational winner picker between the I-cache and D-cache requests.
// ARB_ROUND_ROBIN_EN switches the tie-break from fixed D priority to round robin.
module arb_select
    import arb_types::*;
(
    input  logic     i_req,
    input  logic     d_req,
    input  arb_src_t last_grant,
    output arb_src_t winner,
    output logic     valid
);

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_s;
    assign unused_s = last_grant;
`endif

    // Pick a winner; on a tie the tie-break policy decides.
    always_comb begin
        winner = SRC_D;
        valid  = i_req | d_req;
        if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner = (last_grant == SRC_D) ? SRC_I : SRC_D;
`else
            winner = SRC_D;
`endif
        end else if (d_req) begin
            winner = SRC_D;
        end else if (i_req) begin
            winner = SRC_I;
        end else begin
            winner = SRC_D;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates the single physical-memory port between the I-cache and D-cache.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin tie-break instead of fixed D priority).
module cache_arbiter
    import arb_types::*;
#(
    parameter int LINE_WIDTH = ARB_LINE_WIDTH,
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    arb_state_t            state_r;
    arb_state_t            next_state_s;
    arb_src_t              sel_src_s;
    arb_src_t              last_grant_s;
    logic                  sel_valid_s;
    logic                  grant_s;
    logic                  i_resp_s;
    logic                  d_resp_s;
    logic                  mem_read_r;
    logic                  mem_write_r;
    logic [ADDR_WIDTH-1:0] mem_address_r;
    logic [LINE_WIDTH-1:0] mem_wdata_r;
    logic [LINE_WIDTH-1:0] i_rdata_r;
    logic [LINE_WIDTH-1:0] d_rdata_r;

    arb_select u_select (
        .i_req      (i_pmem_read),
        .d_req      (d_pmem_read | d_pmem_write),
        .last_grant (last_grant_s),
        .winner     (sel_src_s),
        .valid      (sel_valid_s)
    );

    cache_arbiter_chk u_chk (
        .clk          (clk),
        .rst          (rst),
        .d_pmem_read  (d_pmem_read),
        .d_pmem_write (d_pmem_write)
    );

`ifdef ARB_ROUND_ROBIN_EN
    arb_src_t last_grant_r;

    // Remember which cache won the most recent grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= SRC_I;
        end else if (grant_s) begin
            last_grant_r <= sel_src_s;
        end
    end

    assign last_grant_s = last_grant_r;
`else
    assign last_grant_s = SRC_I;
`endif

    // Next-state, grant and response decode.
    always_comb begin
        next_state_s = state_r;
        grant_s      = 1'b0;
        i_resp_s     = 1'b0;
        d_resp_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (sel_valid_s) begin
                    grant_s      = 1'b1;
                    next_state_s = (sel_src_s == SRC_D) ? D_BUSY : I_BUSY;
                end else begin
                    next_state_s = IDLE;
                end
            end
            I_BUSY: begin
                if (mem_resp) begin
                    i_resp_s     = ~rst;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = I_BUSY;
                end
            end
            D_BUSY: begin
                if (mem_resp) begin
                    d_resp_s     = ~rst;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = D_BUSY;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Latch the winner's request on the grant edge; drop strobes after the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
            mem_address_r <= '0;
            mem_wdata_r   <= '0;
            i_rdata_r     <= '0;
            d_rdata_r     <= '0;
        end else begin
            if (grant_s) begin
                if (sel_src_s == SRC_D) begin
                    mem_address_r <= d_pmem_address;
                    mem_wdata_r   <= d_pmem_wdata;
                    mem_write_r   <= d_pmem_write;
                    mem_read_r    <= ~d_pmem_write;
                end else begin
                    mem_address_r <= i_pmem_address;
                    mem_write_r   <= 1'b0;
                    mem_read_r    <= 1'b1;
                end
            end else if (i_resp_s || d_resp_s) begin
                mem_read_r  <= 1'b0;
                mem_write_r <= 1'b0;
            end
            if (i_resp_s) begin
                i_rdata_r <= mem_rdata;
            end
            if (d_resp_s) begin
                d_rdata_r <= mem_rdata;
            end
        end
    end

    assign mem_read     = mem_read_r;
    assign mem_write    = mem_write_r;
    assign mem_address  = mem_address_r;
    assign mem_wdata    = mem_wdata_r;
    assign i_pmem_resp  = i_resp_s;
    assign d_pmem_resp  = d_resp_s;
    // Forward the line in the response cycle, otherwise hold the last line delivered.
    assign i_pmem_rdata = i_resp_s ? mem_rdata : i_rdata_r;
    assign d_pmem_rdata = d_resp_s ? mem_rdata : d_rdata_r;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter; expectations are hand-derived per cycle.
module tb_cache_arbiter;

    logic         clk;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    int total;
    int bad;

    cache_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [255:0] line_a5;
    logic [255:0] line_wd;
    logic [255:0] line_r2;
    logic [255:0] line_r3;
    logic [255:0] line_r4;
    logic [255:0] line_r5;
    logic [255:0] line_r6;
    logic [255:0] line_r7;
    logic [255:0] line_r8;
    logic         i_first;
    logic [31:0]  first_addr;
    logic [31:0]  second_addr;

    initial begin
        total = 0;
        bad   = 0;
        line_a5 = {32{8'hA5}};
        line_wd = {8{32'h1234_5678}};
        line_r2 = {8{32'hCAFE_0002}};
        line_r3 = {8{32'hBEEF_0003}};
        line_r4 = {8{32'hD00D_0004}};
        line_r5 = {8{32'h5555_0005}};
        line_r6 = {8{32'h6666_0006}};
        line_r7 = {8{32'h7777_0007}};
        line_r8 = {8{32'h8888_0008}};
`ifdef ARB_ROUND_ROBIN_EN
        i_first = 1'b1;
`else
        i_first = 1'b0;
`endif
        first_addr  = i_first ? 32'h0000_0680 : 32'h0000_0640;
        second_addr = i_first ? 32'h0000_0640 : 32'h0000_0680;

        rst = 1'b1;
        i_pmem_read = 1'b0;
        i_pmem_address = 32'h0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        d_pmem_address = 32'h0;
        d_pmem_wdata = 256'h0;
        mem_rdata = 256'h0;
        mem_resp = 1'b0;

        // Reset state
        tick();
        tick();
        settle();
        chk("rst_mem_read", {255'h0, mem_read}, 256'h0);
        chk("rst_mem_write", {255'h0, mem_write}, 256'h0);
        chk("rst_mem_address", {224'h0, mem_address}, 256'h0);
        chk("rst_mem_wdata", mem_wdata, 256'h0);
        chk("rst_i_resp", {255'h0, i_pmem_resp}, 256'h0);
        chk("rst_d_resp", {255'h0, d_pmem_resp}, 256'h0);
        chk("rst_i_rdata", i_pmem_rdata, 256'h0);
        chk("rst_d_rdata", d_pmem_rdata, 256'h0);
        rst = 1'b0;

        // Test 1: I-only read at 0x40, memory answers 3 cycles after strobe
        tick();
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0040;
        settle();
        chk("t1_no_strobe_yet", {255'h0, mem_read}, 256'h0);
        tick();
        settle();
        chk("t1_strobe_t1", {255'h0, mem_read}, 256'h1);
        chk("t1_no_write", {255'h0, mem_write}, 256'h0);
        chk("t1_address", {224'h0, mem_address}, 256'h40);
        tick();
        tick();
        settle();
        chk("t1_strobe_held", {255'h0, mem_read}, 256'h1);
        chk("t1_no_early_resp", {255'h0, i_pmem_resp}, 256'h0);
        tick();
        mem_resp = 1'b1;
        mem_rdata = line_a5;
        settle();
        chk("t1_i_resp", {255'h0, i_pmem_resp}, 256'h1);
        chk("t1_i_rdata", i_pmem_rdata, line_a5);
        chk("t1_d_resp", {255'h0, d_pmem_resp}, 256'h0);
        tick();
        mem_resp = 1'b0;
        i_pmem_read = 1'b0;
        settle();
        chk("t1_resp_one_cycle", {255'h0, i_pmem_resp}, 256'h0);
        chk("t1_strobe_drop", {255'h0, mem_read}, 256'h0);
        chk("t1_i_rdata_hold", i_pmem_rdata, line_a5);

        // Stray mem_resp while idle
        tick();
        mem_resp = 1'b1;
        mem_rdata = {32{8'hFF}};
        settle();
        chk("stray_i_resp", {255'h0, i_pmem_resp}, 256'h0);
        chk("stray_d_resp", {255'h0, d_pmem_resp}, 256'h0);
        chk("stray_i_rdata", i_pmem_rdata, line_a5);
        chk("stray_d_rdata", d_pmem_rdata, 256'h0);
        tick();
        mem_resp = 1'b0;
        settle();
        chk("stray_mem_read", {255'h0, mem_read}, 256'h0);
        chk("stray_mem_write", {255'h0, mem_write}, 256'h0);
        chk("stray_address", {224'h0, mem_address}, 256'h40);

        // Test 2: I read 0x80 and D write 0x100 in the same cycle
        tick();
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0080;
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_0100;
        d_pmem_wdata = line_wd;
        tick();
        mem_resp = 1'b1;
        mem_rdata = line_r2;
        settle();
        chk("t2_d_write", {255'h0, mem_write}, 256'h1);
        chk("t2_d_no_read", {255'h0, mem_read}, 256'h0);
        chk("t2_d_address", {224'h0, mem_address}, 256'h100);
        chk("t2_d_wdata", mem_wdata, line_wd);
        chk("t2_d_resp", {255'h0, d_pmem_resp}, 256'h1);
        chk("t2_i_waits", {255'h0, i_pmem_resp}, 256'h0);
        tick();
        mem_resp = 1'b0;
        d_pmem_write = 1'b0;
        settle();
        chk("t2_write_drop", {255'h0, mem_write}, 256'h0);
        chk("t2_read_low_r1", {255'h0, mem_read}, 256'h0);
        tick();
        mem_resp = 1'b1;
        mem_rdata = line_r3;
        settle();
        chk("t2_i_strobe", {255'h0, mem_read}, 256'h1);
        chk("t2_i_address", {224'h0, mem_address}, 256'h80);
        chk("t2_i_resp", {255'h0, i_pmem_resp}, 256'h1);
        chk("t2_i_rdata", i_pmem_rdata, line_r3);
        chk("t2_d_quiet", {255'h0, d_pmem_resp}, 256'h0);
        tick();
        mem_resp = 1'b0;
        i_pmem_read = 1'b0;

        // Test 3: D read 0x200, I arrives and D address changes mid-transaction
        tick();
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_0200;
        tick();
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_00C0;
        d_pmem_address = 32'h0000_0300;
        settle();
        chk("t3_d_strobe", {255'h0, mem_read}, 256'h1);
        chk("t3_address_a", {224'h0, mem_address}, 256'h200);
        tick();
        settle();
        chk("t3_address_held", {224'h0, mem_address}, 256'h200);
        tick();
        mem_resp = 1'b1;
        mem_rdata = line_r4;
        settle();
        chk("t3_d_resp", {255'h0, d_pmem_resp}, 256'h1);
        chk("t3_d_rdata", d_pmem_rdata, line_r4);
        chk("t3_i_quiet", {255'h0, i_pmem_resp}, 256'h0);
        chk("t3_address_at_resp", {224'h0, mem_address}, 256'h200);
        tick();
        mem_resp = 1'b0;
        d_pmem_read = 1'b0;
        settle();
        chk("t3_strobe_low_r1", {255'h0, mem_read}, 256'h0);
        tick();
        mem_resp = 1'b1;
        mem_rdata = line_r5;
        settle();
        chk("t3_i_strobe_r2", {255'h0, mem_read}, 256'h1);
        chk("t3_i_address", {224'h0, mem_address}, 256'hC0);
        chk("t3_i_resp", {255'h0, i_pmem_resp}, 256'h1);
        chk("t3_i_rdata", i_pmem_rdata, line_r5);
        tick();
        mem_resp = 1'b0;
        i_pmem_read = 1'b0;

        // Test 4: reset two cycles into D_BUSY, then a late mem_resp
        tick();
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_0500;
        tick();
        tick();
        rst = 1'b1;
        settle();
        chk("t4_busy_before_rst", {255'h0, mem_read}, 256'h1);
        tick();
        rst = 1'b0;
        d_pmem_read = 1'b0;
        mem_resp = 1'b1;
        mem_rdata = line_r6;
        settle();
        chk("t4_strobe_cleared", {255'h0, mem_read}, 256'h0);
        chk("t4_address_cleared", {224'h0, mem_address}, 256'h0);
        chk("t4_no_d_resp", {255'h0, d_pmem_resp}, 256'h0);
        chk("t4_no_i_resp", {255'h0, i_pmem_resp}, 256'h0);
        chk("t4_d_rdata_cleared", d_pmem_rdata, 256'h0);
        tick();
        mem_resp = 1'b0;
        settle();
        chk("t4_idle_read", {255'h0, mem_read}, 256'h0);
        chk("t4_idle_write", {255'h0, mem_write}, 256'h0);

        // Test 5: back-to-back D reads 0x400 then 0x440
        tick();
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_0400;
        tick();
        mem_resp = 1'b1;
        mem_rdata = line_r7;
        settle();
        chk("t5_addr_a", {224'h0, mem_address}, 256'h400);
        chk("t5_resp_a", {255'h0, d_pmem_resp}, 256'h1);
        chk("t5_rdata_a", d_pmem_rdata, line_r7);
        tick();
        mem_resp = 1'b0;
        d_pmem_address = 32'h0000_0440;
        settle();
        chk("t5_gap_strobe", {255'h0, mem_read}, 256'h0);
        chk("t5_gap_resp", {255'h0, d_pmem_resp}, 256'h0);
        tick();
        settle();
        chk("t5_strobe_b", {255'h0, mem_read}, 256'h1);
        chk("t5_addr_b", {224'h0, mem_address}, 256'h440);
        chk("t5_no_dup_resp", {255'h0, d_pmem_resp}, 256'h0);
        tick();
        mem_resp = 1'b1;
        mem_rdata = line_r8;
        settle();
        chk("t5_resp_b", {255'h0, d_pmem_resp}, 256'h1);
        chk("t5_rdata_b", d_pmem_rdata, line_r8);
        tick();
        mem_resp = 1'b0;
        d_pmem_read = 1'b0;
        settle();
        chk("t5_end_strobe", {255'h0, mem_read}, 256'h0);
        chk("t5_end_resp", {255'h0, d_pmem_resp}, 256'h0);

        // Test 6: D served alone, then both request together
        tick();
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_0600;
        tick();
        mem_resp = 1'b1;
        mem_rdata = line_r2;
        settle();
        chk("t6_solo_d_resp", {255'h0, d_pmem_resp}, 256'h1);
        tick();
        mem_resp = 1'b0;
        d_pmem_address = 32'h0000_0640;
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0680;
        tick();
        mem_resp = 1'b1;
        mem_rdata = line_r3;
        settle();
        chk("t6_first_address", {224'h0, mem_address}, {224'h0, first_addr});
        chk("t6_first_i_resp", {255'h0, i_pmem_resp}, {255'h0, i_first});
        chk("t6_first_d_resp", {255'h0, d_pmem_resp}, {255'h0, ~i_first});
        tick();
        mem_resp = 1'b0;
        i_pmem_read = ~i_first;
        d_pmem_read = i_first;
        tick();
        mem_resp = 1'b1;
        mem_rdata = line_r4;
        settle();
        chk("t6_second_strobe", {255'h0, mem_read}, 256'h1);
        chk("t6_second_address", {224'h0, mem_address}, {224'h0, second_addr});
        chk("t6_second_i_resp", {255'h0, i_pmem_resp}, {255'h0, ~i_first});
        chk("t6_second_d_resp", {255'h0, d_pmem_resp}, {255'h0, i_first});
        tick();
        mem_resp = 1'b0;
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        settle();
        chk("t6_end_strobe", {255'h0, mem_read}, 256'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory port between the I-cache (fetch path feeding the IF stage) and the D-cache (MEM stage).
- Grants one cacheline transaction at a time and latches the winner's address and write data for the whole transaction.
- Routes the response back only to the granted cache.
- Sits between the two caches' pmem-side interfaces and main memory (or L2).

Parameters:
- LINE_WIDTH, 256, cacheline width in bits for rdata/wdata.
- ADDR_WIDTH, 32, line-aligned physical address width.

Ports:
- clk  input  1  clock (all logic on rising edge)
- rst  input  1  synchronous reset, active-high
- i_pmem_read  input  1  I-cache line-fill request (level, held until i_pmem_resp)
- i_pmem_address  input  ADDR_WIDTH  I-cache line address
- i_pmem_rdata  output  LINE_WIDTH  line returned to I-cache
- i_pmem_resp  output  1  one-cycle completion pulse to I-cache
- d_pmem_read  input  1  D-cache line-fill request (level)
- d_pmem_write  input  1  D-cache writeback request (level)
- d_pmem_address  input  ADDR_WIDTH  D-cache line address
- d_pmem_wdata  input  LINE_WIDTH  D-cache writeback line
- d_pmem_rdata  output  LINE_WIDTH  line returned to D-cache
- d_pmem_resp  output  1  one-cycle completion pulse to D-cache
- mem_read  output  1  memory read strobe (level, held until mem_resp)
- mem_write  output  1  memory write strobe (level, held until mem_resp)
- mem_address  output  ADDR_WIDTH  latched address of granted requester
- mem_wdata  output  LINE_WIDTH  latched writeback data
- mem_rdata  input  LINE_WIDTH  line from memory
- mem_resp  input  1  memory completion pulse

Behaviour:
- States: IDLE, I_BUSY, D_BUSY.
- Reset: state=IDLE; mem_read=mem_write=0; mem_address=0; mem_wdata=0; i/d_pmem_resp=0; i/d_pmem_rdata=0.
- All mem_* outputs are registered.
- IDLE, grant decision:
  - d_pmem_read|d_pmem_write high -> D_BUSY.
  - else i_pmem_read high -> I_BUSY.
  - else stay IDLE.
  - Default policy: D-cache has fixed priority.
  - On the grant edge, latch address, wdata (D only) and direction.
- Latency: request visible in IDLE at cycle t -> mem_read/mem_write high from cycle t+1.
- BUSY: mem strobes and latched address/data held constant until mem_resp; requester input changes are ignored.
- On mem_resp in X_BUSY (cycle r):
  - x_pmem_resp=1 and x_pmem_rdata=mem_rdata combinationally in cycle r.
  - The other side's resp stays 0.
  - mem strobes drop at r+1; state -> IDLE at r+1.
  - Next grant is evaluated at r+1, so the earliest new strobe is r+2.
  - The just-served cache must have dropped its request by r+1.
- Simultaneous I and D requests in IDLE: D wins; I waits, its request held.
- d_pmem_read and d_pmem_write both high: illegal. Write takes precedence; flagged by a simulation assertion.
- Requester deasserts before resp: transaction still completes at memory; resp is still pulsed.
- mem_resp in IDLE: ignored, no resp forwarded.
- rst mid-transaction: immediate return to IDLE with all strobes 0 next cycle; a later stray mem_resp is ignored.
- i_pmem_rdata/d_pmem_rdata hold the last value when not responding (no X propagation).

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - 1-bit last_grant register (reset = I).
  - When both caches request in IDLE, grant the one not served most recently.
  - last_grant updates on each grant edge.
- Undefined: fixed D-over-I priority as above; no last_grant register.

Decomposition:
- Shared package arb_types:
  - arb_state_t enum {IDLE, I_BUSY, D_BUSY}
  - arb_src_t enum {SRC_I, SRC_D}
  - LINE_WIDTH default constant
- One sub-module arb_select: combinational winner picker from the two request vectors and last_grant, output arb_src_t plus a valid bit. Its priority logic is the only part changed by ARB_ROUND_ROBIN_EN.

Test Plan:
- I-only read at addr 0x0000_0040; memory responds 3 cycles after strobe with line 0xA5..A5 -> mem_read high t+1, mem_address=0x40, i_pmem_resp 1 cycle with rdata 0xA5..A5, d_pmem_resp stays 0.
- I read 0x80 and D write 0x100 (wdata 0x1234...) same cycle -> D served first (mem_write, address 0x100, wdata exact); after its resp, I served at address 0x80. With ARB_ROUND_ROBIN_EN, the second simultaneous pair goes to I.
- D read 0x200 granted, I request arrives mid-transaction, D changes address to 0x300 -> mem_address stays 0x200 until resp; I granted at resp+1, strobe at resp+2.
- rst asserted 2 cycles into D_BUSY, then mem_resp arrives -> strobes 0 after reset edge, no resp to either cache, state IDLE.
- Back-to-back D reads 0x400, 0x440 with D re-requesting at r+1 -> second strobe exactly at r+2, no lost or duplicated resp.
- Stray mem_resp while IDLE -> no i/d resp pulse, outputs unchanged.
